// File: rtl/sobel_pkg.sv
// Shared constants and FSM encoding for the Sobel edge-pixel UART transmitter.
package sobel_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 5208;
    localparam int unsigned DEF_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sobel_uart_tx_if.sv
// Pixel strobe in, serial line and status out, between edge-detect stage and UART.
interface sobel_uart_tx_if;
    import sobel_pkg::*;

    logic              pi_flag;
    logic [DATA_W-1:0] pi_data;
    logic              tx;
    logic              busy;
    logic              ovf;

    modport master (output pi_flag, output pi_data, input tx, input busy, input ovf);
    modport slave  (input pi_flag, input pi_data, output tx, output busy, output ovf);

endinterface

// File: rtl/sobel_sfifo.sv
// Register-based synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module sobel_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sobel_uart_tx.sv
// Buffers edge pixels and serialises them as 8N1 UART frames, LSB first.
module sobel_uart_tx import sobel_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    sobel_uart_tx_if.slave  bus
);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_ovf;

    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_baud_wrap;

    sobel_sfifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.pi_flag),
        .i_data  (bus.pi_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop        = (r_state == ST_IDLE) && !w_empty;
    assign w_push_ok    = bus.pi_flag && (!w_full || w_pop);
    assign w_baud_wrap  = (r_baud == BAUD_LAST);
    assign w_count_next = w_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (!w_empty) w_state_next = ST_START;
            ST_START: if (w_baud_wrap) w_state_next = ST_DATA;
            ST_DATA:  if (w_baud_wrap && (r_bit == 3'd7)) w_state_next = ST_STOP;
            ST_STOP:  if (w_baud_wrap) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // tx is driven from the pre-edge state, so the line trails the FSM by one clock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE) || (w_count_next != '0);
            if (bus.pi_flag && w_full && !w_pop) r_ovf <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) r_shift <= w_head;
                end
                ST_START: begin
                    r_tx   <= 1'b0;
                    r_baud <= w_baud_wrap ? '0 : r_baud + 1'b1;
                end
                ST_DATA: begin
                    r_tx   <= r_shift[0];
                    r_baud <= w_baud_wrap ? '0 : r_baud + 1'b1;
                    if (w_baud_wrap) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                ST_STOP: begin
                    r_tx   <= 1'b1;
                    r_baud <= w_baud_wrap ? '0 : r_baud + 1'b1;
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_sobel_uart_tx.sv
// Cycle-level check of the UART transmitter against a queue-and-timeline reference model.
module tb_sobel_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;

    sobel_uart_tx_if bus ();

    sobel_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending bytes, the byte on the wire and the edge it was taken.
    byte unsigned q[$];
    byte unsigned cur      = 8'h00;
    int           cyc      = 0;
    int           pop_edge = -1000;
    int           next_pop = 0;
    bit           have     = 1'b0;
    bit           m_ovf    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit r, input bit f, input byte unsigned d);
        cyc++;
        if (r) begin
            q.delete();
            have     = 1'b0;
            m_ovf    = 1'b0;
            next_pop = 0;
        end else begin
            if (q.size() != 0 && cyc >= next_pop) begin
                cur      = q.pop_front();
                have     = 1'b1;
                pop_edge = cyc;
                next_pop = cyc + FRAME + 1;
            end
            if (f) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic exp_tx();
        int off;
        int b;
        off = cyc - pop_edge - 1;
        if (!have || off < 0 || off >= FRAME) return 1'b1;
        b = off / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    function automatic logic exp_busy();
        return (have && (cyc - pop_edge) < FRAME) || (q.size() != 0);
    endfunction

    task automatic step(input bit r, input bit f, input byte unsigned d);
        rst         = r;
        bus.pi_flag = f;
        bus.pi_data = d;
        @(posedge clk);
        model_edge(r, f, d);
        #1;
        check("tx", bus.tx, exp_tx());
        check("busy", bus.busy, exp_busy());
        check("ovf", bus.ovf, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst         = 1'b1;
        bus.pi_flag = 1'b0;
        bus.pi_data = 8'h00;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        check("reset_tx", bus.tx, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_ovf", bus.ovf, 0);

        // Single byte 0xA5
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        check("a5_not_yet_low", bus.tx, 1);
        step(1'b0, 1'b0, 8'h00);
        check("a5_start_low", bus.tx, 0);
        idle(FRAME + 5);
        check("a5_busy_done", bus.busy, 0);

        // Sixteen back-to-back pixels fill the FIFO without loss
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i));
        idle(16 * (FRAME + 1) + 10);
        check("fill16_ovf", bus.ovf, 0);
        check("fill16_busy", bus.busy, 0);

        // Eighteen pixels: the last one is dropped
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'(i));
        check("over18_ovf", bus.ovf, 1);
        idle(17 * (FRAME + 1) + 10);
        check("over18_ovf_sticky", bus.ovf, 1);
        check("over18_busy", bus.busy, 0);

        // Back-to-back 0xFF then 0x00
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h00);
        idle(2 * (FRAME + 1) + 10);

        // Reset mid-frame during data bit 3, then 0x3C
        step(1'b0, 1'b1, 8'hC3);
        idle(1 + CPB + 3 * CPB + 2);
        step(1'b1, 1'b0, 8'h00);
        check("midrst_tx", bus.tx, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ovf", bus.ovf, 0);
        step(1'b0, 1'b1, 8'h3C);
        idle(FRAME + 5);

        // Pixel strobe coincident with reset is ignored
        step(1'b1, 1'b1, 8'h55);
        idle(FRAME + 5);
        check("rstflag_busy", bus.busy, 0);
        check("rstflag_tx", bus.tx, 1);

        // Randomised traffic with varying burst rates and occasional resets
        for (int i = 0; i < 6000; i++) begin
            int rate;
            rate = ((i / 500) % 3 == 0) ? 70 : (((i / 500) % 3 == 1) ? 3 : 20);
            if ($urandom_range(0, 999) == 0)
                step(1'b1, ($urandom_range(0, 1) == 1), 8'($urandom));
            else
                step(1'b0, ($urandom_range(0, 99) < rate), 8'($urandom));
        end
        idle((DEPTH + 1) * (FRAME + 1) + 10);
        check("final_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
